pll_lock_sequencer: RTL
=======================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the number of synchronizer flops on locked_in (legal range 2..4).
REQ-002 Parameter STABLE_CYCLES, default 1024, sets the cycles locked must stay high before hold begins (legal range >=1).
REQ-003 Parameter HOLD_CYCLES, default 16, sets the cycles rst_out stays high after the stable period ends (legal range >=1).
REQ-004 Port clock_in, input, 1 bit: PLL output clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port locked_in, input, 1 bit: raw PLL LOCK, asynchronous to clock_in.
REQ-007 Port restart, input, 1 bit: synchronous pulse that forces re-sequencing.
REQ-008 Port rst_out, output, 1 bit: active-high synchronous reset for downstream logic.
REQ-009 Port ready, output, 1 bit: high only in RUN.
REQ-010 Port state_out, output, 2 bits: current FSM state encoding.
REQ-011 Port lock_lost_count, output, 8 bits: saturating count of lock-loss events.

Function
REQ-012 locked_in SHALL pass through a SYNC_STAGES-deep flop chain; its last stage is lock_sync, and no other logic SHALL sample locked_in.
REQ-013 The FSM SHALL have four states: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
REQ-014 In WAIT_LOCK, when lock_sync=1, the FSM SHALL go to STABLE with cnt=0; otherwise it SHALL stay in WAIT_LOCK.
REQ-015 In STABLE, cnt SHALL increment each cycle; at cnt==STABLE_CYCLES-1 the FSM SHALL go to HOLD with cnt=0, so STABLE lasts exactly STABLE_CYCLES cycles.
REQ-016 In HOLD, cnt SHALL increment each cycle; at cnt==HOLD_CYCLES-1 the FSM SHALL go to RUN, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-017 In STABLE, HOLD or RUN, lock_sync=0 SHALL force WAIT_LOCK at the next edge with cnt=0; this has priority over every count-complete transition.
REQ-018 restart=1 in any state SHALL force WAIT_LOCK at the next edge; lock_sync=0 and restart together SHALL be treated as a single lock-loss transition.
REQ-019 rst_out SHALL equal (state!=RUN) and ready SHALL equal (state==RUN), both decoded directly from the state register with no extra delay.
REQ-020 Latency: from the first edge that samples locked_in=1, with the lock held, rst_out SHALL fall after exactly SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges.
REQ-021 Lock loss in RUN SHALL raise rst_out within SYNC_STAGES+1 edges of locked_in falling.
REQ-022 cnt SHALL be $clog2(max(STABLE_CYCLES,HOLD_CYCLES)+1) bits wide and SHALL never wrap.
REQ-023 A locked_in glitch shorter than one clock period SHALL either be ignored or restart the sequence; it SHALL NOT shorten STABLE or HOLD.

Reset
REQ-024 While reset=1, the block SHALL be in: state=WAIT_LOCK, cnt=0, synchronizer chain=0, rst_out=1, ready=0, lock_lost_count=0.
REQ-025 Reset asserted mid-sequence or in RUN SHALL take effect immediately, independent of clock_in; after deassertion, sequencing SHALL restart from WAIT_LOCK.

Configuration
REQ-026 Macro PLL_LOCK_COUNTER_EN defined: lock_lost_count SHALL increment by 1 on each RUN->WAIT_LOCK transition caused by lock_sync=0 (not restart), saturating at 255.
REQ-027 Macro PLL_LOCK_COUNTER_EN undefined: lock_lost_count SHALL be tied to 0 and no counter flops SHALL be inferred.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4)
REQ-028 Reset released, then locked_in held high -> rst_out falls and ready rises exactly 15 edges after the first edge that samples locked_in=1.
REQ-029 locked_in drops for 3 cycles during STABLE at cnt=5 -> state returns to WAIT_LOCK; after relock, a full 15-edge sequence is required.
REQ-030 locked_in drops in RUN -> rst_out=1 within 3 edges; lock_lost_count goes 0->1 with the macro defined and stays 0 without it.
REQ-031 restart pulse for 1 cycle in RUN with lock steady -> rst_out high for 13 cycles (1+8+4), then RUN again; lock_lost_count unchanged.
REQ-032 300 lock-loss events in RUN with the macro defined -> lock_lost_count saturates and reads 255.
REQ-033 reset asserted asynchronously in HOLD -> rst_out=1, ready=0, state_out=0 before the next clock edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: synchronizes LOCK, waits for a stable period, then holds reset before RUN.
// Define PLL_LOCK_COUNTER_EN to enable the saturating lock-loss counter on lock_lost_count.
module pll_lock_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked_in,
    input  logic       restart,
    output logic       rst_out,
    output logic       ready,
    output logic [1:0] state_out,
    output logic [7:0] lock_lost_count
);

    localparam int unsigned CntMax = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStable   = 2'd1,
        StHold     = 2'd2,
        StRun      = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lock_sync;
    logic                   abort;

    assign lock_sync = sync_q[SYNC_STAGES-1];

    // Lock loss and restart share one path back to WAIT_LOCK and beat any count completion.
    assign abort = restart || ((state_q != StWaitLock) && !lock_sync);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], locked_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = StWaitLock;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    cnt_d = '0;
                    if (lock_sync) begin
                        state_d = StStable;
                    end
                end
                StStable: begin
                    if (cnt_q == StableLast) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (cnt_q == HoldLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= StWaitLock;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rst_out   = (state_q != StRun);
    assign ready     = (state_q == StRun);
    assign state_out = state_q;

`ifdef PLL_LOCK_COUNTER_EN
    logic [7:0] lost_q, lost_d;

    // Only a genuine lock drop out of RUN counts; a bare restart does not.
    always_comb begin
        lost_d = lost_q;
        if ((state_q == StRun) && !lock_sync && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            lost_q <= '0;
        end else begin
            lost_q <= lost_d;
        end
    end

    assign lock_lost_count = lost_q;
`else
    assign lock_lost_count = '0;
`endif

endmodule
